// File: rtl/queues_reader_pkg.sv
// Shared MemorEDF definitions for the queues reader: default sizes, FSM
// state encoding and a small index helper used by the round-robin search.
package queues_reader_pkg;

   localparam int DEF_NUMBER_OF_QUEUES = 4;
   localparam int DEF_DATA_SIZE        = 678;
   localparam int DEF_REGISTER_SIZE    = 32;

   // IDLE: look for work, REQ: ready high waiting for the queue's valid,
   // OUT: holding the captured packet until downstream accepts it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      OUT  = 2'd2
   } state_t;

   // Next queue index with wrap-around; avoids relying on a power-of-two count.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/queues_reader_if.sv
// Bundle of the queue-side request/packet signals and the downstream
// packet stream. master = the reader, slave = queues + downstream consumer.
interface queues_reader_if
   import queues_reader_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
   parameter int DATA_SIZE        = DEF_DATA_SIZE,
   parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE
) ();

   localparam int IDX_W = $clog2(NUMBER_OF_QUEUES);

   // queueing-domain side
   logic [NUMBER_OF_QUEUES-1:0]                    empty;
   logic [NUMBER_OF_QUEUES-1:0]                    enable_mask;
   logic                                           queues_to_serializer_valid;
   logic [DATA_SIZE-1:0]                           queues_to_serializer_packet;
   logic                                           scheduler_to_queues_ready;
   logic [IDX_W-1:0]                               core_id;

   // downstream side
   logic                                           m_valid;
   logic                                           m_ready;
   logic [DATA_SIZE-1:0]                           m_packet;
   logic [IDX_W-1:0]                               m_core_id;

   // statistics
   logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_count;

   modport master (
      input  empty, enable_mask, queues_to_serializer_valid,
             queues_to_serializer_packet, m_ready,
      output scheduler_to_queues_ready, core_id, m_valid, m_packet,
             m_core_id, served_count
   );

   modport slave (
      output empty, enable_mask, queues_to_serializer_valid,
             queues_to_serializer_packet, m_ready,
      input  scheduler_to_queues_ready, core_id, m_valid, m_packet,
             m_core_id, served_count
   );

endinterface

// File: rtl/queues_reader_rr_arbiter.sv
// Round-robin pick: first requesting index strictly after last_grant,
// wrapping around. Purely combinational; the caller owns last_grant.
module rr_arbiter
   import queues_reader_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
   localparam int IDX_W = $clog2(NUMBER_OF_QUEUES)
) (
   input  logic [NUMBER_OF_QUEUES-1:0] req,
   input  logic [IDX_W-1:0]            last_grant,
   output logic [IDX_W-1:0]            winner,
   output logic                        any_req
);

   int   idx;
   logic found;

   // Walk the N candidates starting after last_grant; the first hit wins.
   always_comb begin
      winner  = '0;
      any_req = |req;
      found   = 1'b0;
      idx     = int'(last_grant);
      for (int k = 0; k < NUMBER_OF_QUEUES; k++) begin
         idx = wrap_inc(idx, NUMBER_OF_QUEUES);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/queues_reader.sv
// Pops one packet at a time from a round-robin selected per-core queue and
// hands it downstream with a valid/ready handshake, counting deliveries.
module queues_reader
   import queues_reader_pkg::*;
#(
   parameter int NUMBER_OF_QUEUES = DEF_NUMBER_OF_QUEUES,
   parameter int DATA_SIZE        = DEF_DATA_SIZE,
   parameter int REGISTER_SIZE    = DEF_REGISTER_SIZE
) (
   input logic             clock,
   input logic             reset,
   queues_reader_if.master bus
);

   localparam int IDX_W = $clog2(NUMBER_OF_QUEUES);

   state_t                                         state_q, state_d;
   logic                                           ready_q, ready_d;
   logic [IDX_W-1:0]                               core_id_q, core_id_d;
   logic [IDX_W-1:0]                               last_grant_q, last_grant_d;
   logic                                           m_valid_q, m_valid_d;
   logic [DATA_SIZE-1:0]                           m_packet_q, m_packet_d;
   logic [IDX_W-1:0]                               m_core_id_q, m_core_id_d;
   logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_count_q, served_count_d;

   logic [NUMBER_OF_QUEUES-1:0]                    eligible;
   logic [IDX_W-1:0]                               rr_winner;
   logic                                           rr_any;

   assign eligible = ~bus.empty & bus.enable_mask;

   rr_arbiter #(
      .NUMBER_OF_QUEUES (NUMBER_OF_QUEUES)
   ) u_rr_arbiter (
      .req        (eligible),
      .last_grant (last_grant_q),
      .winner     (rr_winner),
      .any_req    (rr_any)
   );

   // Next-state logic: grant in IDLE, capture on valid in REQ, drain in OUT.
   // eligible is only looked at in IDLE, so a granted request always finishes.
   always_comb begin
      state_d        = state_q;
      ready_d        = ready_q;
      core_id_d      = core_id_q;
      last_grant_d   = last_grant_q;
      m_valid_d      = m_valid_q;
      m_packet_d     = m_packet_q;
      m_core_id_d    = m_core_id_q;
      served_count_d = served_count_q;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               // core_id is the queue RAM read address: it only moves here
               core_id_d    = rr_winner;
               last_grant_d = rr_winner;
               ready_d      = 1'b1;
               state_d      = REQ;
            end
         end
         REQ: begin
            if (bus.queues_to_serializer_valid) begin
               m_packet_d  = bus.queues_to_serializer_packet;
               m_core_id_d = core_id_q;
               ready_d     = 1'b0;
               m_valid_d   = 1'b1;
               state_d     = OUT;
            end
         end
         OUT: begin
            if (m_valid_q && bus.m_ready) begin
               m_valid_d                   = 1'b0;
               served_count_d[m_core_id_q] = served_count_q[m_core_id_q] + REGISTER_SIZE'(1);
               state_d                     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b0;
         end
      endcase
   end

   // State register; reset aborts any in-flight transaction without counting it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= IDLE;
         ready_q        <= 1'b0;
         core_id_q      <= '0;
         last_grant_q   <= IDX_W'(NUMBER_OF_QUEUES - 1);
         m_valid_q      <= 1'b0;
         m_packet_q     <= '0;
         m_core_id_q    <= '0;
         served_count_q <= '0;
      end else begin
         state_q        <= state_d;
         ready_q        <= ready_d;
         core_id_q      <= core_id_d;
         last_grant_q   <= last_grant_d;
         m_valid_q      <= m_valid_d;
         m_packet_q     <= m_packet_d;
         m_core_id_q    <= m_core_id_d;
         served_count_q <= served_count_d;
      end
   end

   assign bus.scheduler_to_queues_ready = ready_q;
   assign bus.core_id                   = core_id_q;
   assign bus.m_valid                   = m_valid_q;
   assign bus.m_packet                  = m_packet_q;
   assign bus.m_core_id                 = m_core_id_q;
   assign bus.served_count              = served_count_q;

endmodule

// File: tb/tb_queues_reader.sv
// Directed bench for queues_reader: transaction-level model checked every
// cycle, plus literal expectations for the scenarios of interest.
module tb_queues_reader;
   import queues_reader_pkg::*;

   localparam int N  = DEF_NUMBER_OF_QUEUES;
   localparam int D  = DEF_DATA_SIZE;
   localparam int R  = DEF_REGISTER_SIZE;
   localparam int IW = $clog2(N);
   typedef logic [1023:0] cw_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   queues_reader_if #(.NUMBER_OF_QUEUES(N), .DATA_SIZE(D), .REGISTER_SIZE(R)) bus ();

   queues_reader #(
      .NUMBER_OF_QUEUES (N),
      .DATA_SIZE        (D),
      .REGISTER_SIZE    (R)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input cw_t act, input cw_t exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- model ----------------
   bit             mdl_live = 1'b0;
   bit             mdl_req, mdl_out;
   int             mdl_last;
   logic [IW-1:0]  mdl_core, mdl_mcore;
   logic [D-1:0]   mdl_pkt;
   logic [R-1:0]   mdl_cnt [N];
   bit             preload_pending = 1'b0;

   function automatic int rr_pick(input logic [N-1:0] elig, input int last);
      for (int k = 1; k <= N; k++)
         if (elig[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   always @(posedge clock) begin : model
      int pick;
      if (reset) begin
         mdl_live  <= 1'b1;
         mdl_req   <= 1'b0;
         mdl_out   <= 1'b0;
         mdl_last  <= N - 1;
         mdl_core  <= '0;
         mdl_mcore <= '0;
         mdl_pkt   <= '0;
         for (int i = 0; i < N; i++) mdl_cnt[i] <= '0;
      end else begin
         if (preload_pending) mdl_cnt[1] <= '1;
         if (mdl_out) begin
            if (bus.m_ready) begin
               mdl_out <= 1'b0;
               mdl_cnt[mdl_mcore] <= mdl_cnt[mdl_mcore] + 1'b1;
            end
         end else if (mdl_req) begin
            if (bus.queues_to_serializer_valid) begin
               mdl_req   <= 1'b0;
               mdl_out   <= 1'b1;
               mdl_pkt   <= bus.queues_to_serializer_packet;
               mdl_mcore <= mdl_core;
            end
         end else begin
            pick = rr_pick(~bus.empty & bus.enable_mask, mdl_last);
            if (pick >= 0) begin
               mdl_core <= IW'(pick);
               mdl_last <= pick;
               mdl_req  <= 1'b1;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (mdl_live) begin
         chk("ready",     cw_t'(bus.scheduler_to_queues_ready), cw_t'(mdl_req));
         chk("core_id",   cw_t'(bus.core_id),   cw_t'(mdl_core));
         chk("m_valid",   cw_t'(bus.m_valid),   cw_t'(mdl_out));
         chk("m_packet",  cw_t'(bus.m_packet),  cw_t'(mdl_pkt));
         chk("m_core_id", cw_t'(bus.m_core_id), cw_t'(mdl_mcore));
         for (int i = 0; i < N; i++)
            chk($sformatf("served_count[%0d]", i), cw_t'(bus.served_count[i]), cw_t'(mdl_cnt[i]));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ready();
      int n = 0;
      while (!bus.scheduler_to_queues_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("ready_rise", cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b1));
   endtask

   // Returns at the first cycle m_valid should be high.
   task automatic txn(input logic [D-1:0] pkt, output logic [IW-1:0] gid);
      wait_ready();
      gid = bus.core_id;
      @(negedge clock);
      bus.queues_to_serializer_valid  = 1'b1;
      bus.queues_to_serializer_packet = pkt;
      @(negedge clock);
      bus.queues_to_serializer_valid  = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.m_valid && n < 20) begin
         @(negedge clock);
         n++;
      end
      chk("m_valid_drop", cw_t'(bus.m_valid), cw_t'(1'b0));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   logic [N-1:0][R-1:0] preload_v;

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [IW-1:0] gid;
      logic [D-1:0]  pkt;
      int            exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

      reset = 1'b1;
      bus.empty = '1;
      bus.enable_mask = '1;
      bus.queues_to_serializer_valid = 1'b0;
      bus.queues_to_serializer_packet = '0;
      bus.m_ready = 1'b0;
      repeat (3) @(negedge clock);

      // reset values
      chk("rst_ready",      cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b0));
      chk("rst_m_valid",    cw_t'(bus.m_valid), cw_t'(1'b0));
      chk("rst_core_id",    cw_t'(bus.core_id), cw_t'(0));
      chk("rst_state",      cw_t'(dut.state_q), cw_t'(IDLE));
      chk("rst_last_grant", cw_t'(dut.last_grant_q), cw_t'(3));

      // basic latency: empty=1011 -> queue 2
      reset = 1'b0;
      bus.empty = 4'b1011;                     // cycle 0
      @(negedge clock);                        // cycle 1
      chk("a_ready",   cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b1));
      chk("a_core_id", cw_t'(bus.core_id), cw_t'(2));
      bus.empty = '1;                          // ignored while in REQ
      @(negedge clock);                        // cycle 2
      bus.queues_to_serializer_valid  = 1'b1;
      bus.queues_to_serializer_packet = D'(8'hA5);
      @(negedge clock);                        // cycle 3
      bus.queues_to_serializer_valid  = 1'b0;
      chk("a_m_valid",   cw_t'(bus.m_valid), cw_t'(1'b1));
      chk("a_m_packet",  cw_t'(bus.m_packet), cw_t'(8'hA5));
      chk("a_m_core_id", cw_t'(bus.m_core_id), cw_t'(2));
      bus.m_ready = 1'b1;
      wait_done();
      chk("a_served2", cw_t'(bus.served_count[2]), cw_t'(1));

      // backpressure: 5 cycles with m_ready low
      bus.m_ready = 1'b0;
      bus.empty = '0;
      pkt = D'(64'hDEAD_BEEF_0123_4567);
      txn(pkt, gid);
      bus.empty = '1;
      chk("b_grant", cw_t'(gid), cw_t'(3));
      repeat (5) begin
         chk("b_m_valid_hold",  cw_t'(bus.m_valid), cw_t'(1'b1));
         chk("b_m_packet_hold", cw_t'(bus.m_packet), cw_t'(pkt));
         chk("b_ready_low",     cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b0));
         @(negedge clock);
      end
      bus.m_ready = 1'b1;
      wait_done();
      chk("b_served3", cw_t'(bus.served_count[3]), cw_t'(1));

      // stray valid while idle is ignored
      bus.queues_to_serializer_valid  = 1'b1;
      bus.queues_to_serializer_packet = D'(16'hBAD0);
      @(negedge clock);
      bus.queues_to_serializer_valid  = 1'b0;
      @(negedge clock);
      chk("c_stray_m_valid", cw_t'(bus.m_valid), cw_t'(1'b0));
      chk("c_stray_packet",  cw_t'(bus.m_packet), cw_t'(pkt));

      // round-robin order with all queues busy
      do_reset();
      bus.empty = '0;
      for (int i = 0; i < 8; i++) begin
         txn(D'(32'h100 + i), gid);
         chk($sformatf("rr_order[%0d]", i), cw_t'(gid), cw_t'(exp_order[i]));
         if (i == 7) bus.empty = '1;
         wait_done();
      end
      for (int i = 0; i < N; i++)
         chk($sformatf("rr_served[%0d]", i), cw_t'(bus.served_count[i]), cw_t'(2));

      // enable mask: only queue 0, then nothing
      bus.enable_mask = 4'b0001;
      bus.empty = '0;
      for (int i = 0; i < 3; i++) begin
         txn(D'(32'h200 + i), gid);
         chk("mask_grant0", cw_t'(gid), cw_t'(0));
         if (i == 2) bus.enable_mask = '0;
         wait_done();
      end
      repeat (10) begin
         chk("mask0_no_ready", cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b0));
         @(negedge clock);
      end
      chk("mask_served0", cw_t'(bus.served_count[0]), cw_t'(5));

      // reset in the middle of REQ
      bus.enable_mask = '1;
      bus.empty = '1;
      do_reset();
      bus.empty = 4'b1011;
      @(negedge clock);
      chk("r_ready_req", cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b1));
      reset = 1'b1;
      @(negedge clock);
      chk("r_ready_low", cw_t'(bus.scheduler_to_queues_ready), cw_t'(1'b0));
      chk("r_state",     cw_t'(dut.state_q), cw_t'(IDLE));
      for (int i = 0; i < N; i++)
         chk($sformatf("r_served[%0d]", i), cw_t'(bus.served_count[i]), cw_t'(0));
      reset = 1'b0;
      bus.empty = '0;
      txn(D'(16'h3030), gid);
      bus.empty = '1;
      chk("r_first_grant", cw_t'(gid), cw_t'(0));
      wait_done();

      // counter wrap: preload queue 1 to all-ones
      preload_pending = 1'b1;
      preload_v = bus.served_count;
      preload_v[1] = '1;
      @(posedge clock);
      #2;
      force dut.served_count_q = preload_v;
      preload_pending = 1'b0;
      @(posedge clock);
      #2;
      release dut.served_count_q;
      @(negedge clock);
      chk("w_preload", cw_t'(bus.served_count[1]), cw_t'(32'hFFFF_FFFF));
      bus.enable_mask = 4'b0010;
      bus.empty = '0;
      txn(D'(16'h4141), gid);
      bus.empty = '1;
      chk("w_grant1", cw_t'(gid), cw_t'(1));
      wait_done();
      chk("w_wrap", cw_t'(bus.served_count[1]), cw_t'(0));
      chk("w_other", cw_t'(bus.served_count[0]), cw_t'(1));

      repeat (2) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/queues_reader.md
QUEUES_READER -- requirements
Module: queues_reader

Interface
REQ-001 The block SHALL have parameter NUMBER_OF_QUEUES, default 4, meaning the number of per-core queues served.
REQ-002 The block SHALL have parameter DATA_SIZE, default 678, meaning the packet width in bits.
REQ-003 The block SHALL have parameter REGISTER_SIZE, default 32, meaning the width of each served-packet counter.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port empty, input, NUMBER_OF_QUEUES bits: per-queue empty flags from the queueing domain.
REQ-007 The block SHALL have port enable_mask, input, NUMBER_OF_QUEUES bits: a 0 bit excludes that queue from selection.
REQ-008 The block SHALL have port queues_to_serializer_valid, input, 1 bit: a 1-cycle pulse marking the packet as valid.
REQ-009 The block SHALL have port queues_to_serializer_packet, input, DATA_SIZE bits: the head packet of the selected queue.
REQ-010 The block SHALL have port scheduler_to_queues_ready, output, 1 bit: request; its rising edge pops one head.
REQ-011 The block SHALL have port core_id, output, $clog2(NUMBER_OF_QUEUES) bits: the selected queue index.
REQ-012 The block SHALL have port m_valid, output, 1 bit: downstream packet valid.
REQ-013 The block SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-014 The block SHALL have ports m_packet (output, DATA_SIZE bits) and m_core_id (output, $clog2(NUMBER_OF_QUEUES) bits): the captured packet and its source queue.
REQ-015 The block SHALL have port served_count, output, NUMBER_OF_QUEUES x REGISTER_SIZE bits: packets delivered per queue.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ and OUT.
REQ-017 In IDLE, eligible = ~empty & enable_mask; if eligible is nonzero, the FSM SHALL register core_id = round-robin winner, set ready to 1 and go to REQ.
REQ-018 Round-robin search SHALL start at (last_grant+1) mod NUMBER_OF_QUEUES and take the first eligible index; last_grant updates on each grant.
REQ-019 In REQ, ready SHALL stay 1 until queues_to_serializer_valid is sampled high.
REQ-020 On that valid edge, the block SHALL capture m_packet = queues_to_serializer_packet and m_core_id = core_id, set ready to 0 and m_valid to 1, and go to OUT.
REQ-021 In OUT, m_valid, m_packet and m_core_id SHALL hold until m_valid & m_ready; on that edge m_valid goes to 0, served_count[m_core_id] increments, and the FSM returns to IDLE.
REQ-022 core_id SHALL be constant from the grant edge until the next grant, because the queue RAM read address depends on it.
REQ-023 ready SHALL be low for at least 2 cycles between transactions (OUT plus IDLE), so every request is a fresh rising edge and pops exactly one entry.
REQ-024 Latency SHALL be: eligible seen in IDLE at cycle 0, ready=1 at cycle 1, valid at cycle 2, m_valid=1 at cycle 3.
REQ-025 Changes to empty or enable_mask during REQ or OUT SHALL be ignored; a granted request always completes.
REQ-026 If eligible is 0, the FSM SHALL stay in IDLE with ready=0 and last_grant unchanged.
REQ-027 A valid pulse received outside REQ SHALL be ignored.
REQ-028 served_count SHALL wrap from 2^REGISTER_SIZE-1 to 0 without any flag.

Reset
REQ-029 On reset the block SHALL set state=IDLE, ready=0, core_id=0, m_valid=0, m_packet=0, m_core_id=0, served_count=0 and last_grant=NUMBER_OF_QUEUES-1, so queue 0 wins first.
REQ-030 A reset in any state, including mid-REQ, SHALL abort the transaction, and no counter SHALL increment.

Structure
REQ-031 The state enum and the default parameter values SHALL live in the shared MemorEDF package.
REQ-032 The round-robin search SHALL be one sub-module, rr_arbiter (inputs: request vector and last_grant; output: winner and any-request).

Verification
REQ-033 Reset, empty=4'b1011 -> at cycle 1 core_id=2 and ready=1; valid pulse at cycle 2 with packet 0xA5 -> at cycle 3 m_valid=1, m_packet=0xA5, m_core_id=2.
REQ-034 All queues non-empty, m_ready tied 1, 8 transactions -> grant order 0,1,2,3,0,1,2,3 and served_count each 2.
REQ-035 m_ready held 0 for 5 cycles in OUT -> m_valid and m_packet stable; ready stays 0; no new grant until the handshake completes.
REQ-036 enable_mask=4'b0001 and empty=4'b0000 -> only core_id=0 is granted; enable_mask=0 -> ready never rises.
REQ-037 Reset asserted in the REQ cycle -> next cycle ready=0, state IDLE, served_count unchanged; queue 0 is granted first after reset.
REQ-038 served_count[1] preloaded via force to 0xFFFFFFFF, one queue-1 delivery -> served_count[1]=0.
